rst_seq_ctrl: RTL and testbench

Reset sequencer for the ADC readout system. Arbitrates soft-reset requests from several requesters and the clock manager's lock status. Drives N_STAGE active-high reset lines that assert together and release in a fixed order once the clock is locked. Its outputs are registered and feed the per-domain reset synchronisers/global buffers.

---
 rtl/rst_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all stage resets together on a request or lock loss,
// then releases them in index order once the clock manager is locked (or after a lock timeout).
module rst_seq_ctrl #(
    parameter int N_REQ        = 2,
    parameter int N_STAGE      = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic                         locked,
    output logic [N_STAGE-1:0]           rst_stage,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [$clog2(N_REQ+1)-1:0]   req_src
);
    localparam int M1   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CMAX = (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(N_REQ + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SRC_LOCK  = SW'(N_REQ);

    typedef enum logic [2:0] {IDLE, HOLD, WAIT_LOCK, RELEASE, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_STAGE-1:0] stage_q, stage_d;
    logic               to_q, to_d;
    logic [SW-1:0]      src_q, src_d;
    logic               req_hit;
    logic [SW-1:0]      req_idx;

    assign req_hit = |req;

    always_comb begin
        req_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) req_idx = SW'(i);
    end

    // Reset value equals the state one edge before an accept, so the first
    // edge after rst_n rises behaves exactly like an accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= CW'(HOLD_CYCLES);
            stage_q <= '1;
            to_q    <= 1'b0;
            src_q   <= SRC_LOCK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            to_q    <= to_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        to_d    = to_q;
        src_d   = src_q;
        case (state_q)
            IDLE, FIN: begin
                if (req_hit || !locked) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    stage_d = '1;
                    to_d    = 1'b0;
                    src_d   = req_hit ? req_idx : SRC_LOCK;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked || cnt_q == LOCK_LAST) begin
                    if (!locked) to_d = 1'b1;
                    stage_d = stage_q << 1;
                    cnt_d   = GAP_LOAD;
                    state_d = (stage_d == '0) ? FIN : RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                // A forced (timed-out) release keeps going even without lock.
                if (req_hit || (!locked && !to_q)) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    stage_d = '1;
                    to_d    = 1'b0;
                    src_d   = req_hit ? req_idx : SRC_LOCK;
                end else if (cnt_q == '0) begin
                    stage_d = stage_q << 1;
                    cnt_d   = GAP_LOAD;
                    state_d = (stage_d == '0) ? FIN : RELEASE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rst_stage = stage_q;
    assign busy      = (state_q != IDLE) && (state_q != FIN);
    assign done      = (state_q == FIN);
    assign timeout   = to_q;
    assign req_src   = src_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: vector table for the main sequences plus
// hand-written abort and asynchronous-reset sequences.
module tb_rst_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic       locked;
    logic [2:0] rst_stage;
    logic       busy, done, timeout;
    logic [1:0] req_src;

    int checks = 0;
    int errors = 0;

    rst_seq_ctrl #(.N_REQ(2), .N_STAGE(3), .HOLD_CYCLES(16), .STAGE_GAP(8), .LOCK_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .locked(locked),
        .rst_stage(rst_stage), .busy(busy), .done(done), .timeout(timeout), .req_src(req_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] req;
        logic       locked;
        int         adv;
        logic [2:0] stg;
        logic       bsy;
        logic       dn;
        logic       to;
        logic [1:0] src;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic [1:0] r, input logic l, input int a,
                       input logic [2:0] s, input logic b, input logic d, input logic t,
                       input logic [1:0] src);
        vec_t v;
        v.name = n; v.req = r; v.locked = l; v.adv = a;
        v.stg = s; v.bsy = b; v.dn = d; v.to = t; v.src = src;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [2:0] s, input logic b, input logic d,
                       input logic t, input logic [1:0] src);
        checks++;
        if ({rst_stage, busy, done, timeout, req_src} !== {s, b, d, t, src}) begin
            errors++;
            $display("FAIL %s: got stage=%b busy=%b done=%b timeout=%b src=%0d, want stage=%b busy=%b done=%b timeout=%b src=%0d",
                     n, rst_stage, busy, done, timeout, req_src, s, b, d, t, src);
        end
    endtask

    initial begin
        // power-on: edge 0 is the first edge after rst_n rises
        add("por_e0",   2'b00, 1'b1,  1, 3'b111, 1, 0, 0, 2);
        add("por_e16",  2'b00, 1'b1, 16, 3'b111, 1, 0, 0, 2);
        add("por_e17",  2'b00, 1'b1,  1, 3'b110, 1, 0, 0, 2);
        add("por_e24",  2'b00, 1'b1,  7, 3'b110, 1, 0, 0, 2);
        add("por_e25",  2'b00, 1'b1,  1, 3'b100, 1, 0, 0, 2);
        add("por_e32",  2'b00, 1'b1,  7, 3'b100, 1, 0, 0, 2);
        add("por_e33",  2'b00, 1'b1,  1, 3'b000, 0, 1, 0, 2);
        add("por_idle", 2'b00, 1'b1,  1, 3'b000, 0, 0, 0, 2);
        // both requesters at once: index 0 wins
        add("req11_t",   2'b11, 1'b1,  1, 3'b111, 1, 0, 0, 0);
        add("req11_t16", 2'b00, 1'b1, 16, 3'b111, 1, 0, 0, 0);
        add("req11_t17", 2'b00, 1'b1,  1, 3'b110, 1, 0, 0, 0);
        add("req11_t33", 2'b00, 1'b1, 16, 3'b000, 0, 1, 0, 0);
        add("req11_idle",2'b00, 1'b1,  1, 3'b000, 0, 0, 0, 0);
        // lock missing through WAIT_LOCK: forced release at t+80
        add("to_t",      2'b01, 1'b1,  1, 3'b111, 1, 0, 0, 0);
        add("to_t16",    2'b00, 1'b0, 16, 3'b111, 1, 0, 0, 0);
        add("to_t79",    2'b00, 1'b0, 63, 3'b111, 1, 0, 0, 0);
        add("to_t80",    2'b00, 1'b0,  1, 3'b110, 1, 0, 1, 0);
        add("to_t88",    2'b00, 1'b0,  8, 3'b100, 1, 0, 1, 0);
        add("to_t96",    2'b00, 1'b0,  8, 3'b000, 0, 1, 1, 0);
        add("to_sticky", 2'b00, 1'b1,  1, 3'b000, 0, 0, 1, 0);
        add("to_sticky2",2'b00, 1'b1,  3, 3'b000, 0, 0, 1, 0);
        // lock loss in IDLE, lock returns at t+30
        add("ll_t",      2'b00, 1'b0,  1, 3'b111, 1, 0, 0, 2);
        add("ll_t16",    2'b00, 1'b0, 16, 3'b111, 1, 0, 0, 2);
        add("ll_t29",    2'b00, 1'b0, 13, 3'b111, 1, 0, 0, 2);
        add("ll_t30",    2'b00, 1'b1,  1, 3'b110, 1, 0, 0, 2);
        add("ll_t38",    2'b00, 1'b1,  8, 3'b100, 1, 0, 0, 2);
        add("ll_t46",    2'b00, 1'b1,  8, 3'b000, 0, 1, 0, 2);
        add("ll_idle",   2'b00, 1'b1,  1, 3'b000, 0, 0, 0, 2);
        // request beats lock loss in the same cycle
        add("prio_t",    2'b10, 1'b0,  1, 3'b111, 1, 0, 0, 1);
        add("prio_t33",  2'b00, 1'b1, 33, 3'b000, 0, 1, 0, 1);
        add("prio_idle", 2'b00, 1'b1,  1, 3'b000, 0, 0, 0, 1);

        rst_n = 1'b0; req = 2'b00; locked = 1'b1;
        step(2);
        chk("reset_vals", 3'b111, 1, 0, 0, 2);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req = tbl[i].req;
            locked = tbl[i].locked;
            step(tbl[i].adv);
            chk(tbl[i].name, tbl[i].stg, tbl[i].bsy, tbl[i].dn, tbl[i].to, tbl[i].src);
        end

        // request abort during RELEASE, then lock-loss abort
        req = 2'b01; step(1);
        chk("ab_t", 3'b111, 1, 0, 0, 0);
        req = 2'b00; step(17);
        chk("ab_t17", 3'b110, 1, 0, 0, 0);
        step(2);
        req = 2'b10; step(1);
        chk("ab_t20", 3'b111, 1, 0, 0, 1);
        req = 2'b00; step(16);
        chk("ab_t36", 3'b111, 1, 0, 0, 1);
        step(1);
        chk("ab_t37", 3'b110, 1, 0, 0, 1);
        locked = 1'b0; step(1);
        chk("ab_lock", 3'b111, 1, 0, 0, 2);
        locked = 1'b1; step(17);
        chk("ab_lock_s0", 3'b110, 1, 0, 0, 2);
        step(16);
        chk("ab_lock_done", 3'b000, 0, 1, 0, 2);
        step(1);

        // asynchronous reset mid-RELEASE
        req = 2'b01; step(1);
        req = 2'b00; step(20);
        chk("ar_pre", 3'b110, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk("ar_async", 3'b111, 1, 0, 0, 2);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("ar_e0", 3'b111, 1, 0, 0, 2);
        step(17);
        chk("ar_e17", 3'b110, 1, 0, 0, 2);
        step(16);
        chk("ar_e33", 3'b000, 0, 1, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
